// File: rtl/sync_dff_pkg.sv
// Shared defaults and helpers for the sync_dff register pipeline.
package sync_dff_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_DEPTH = 1;

    // Smallest n with 2**n >= v; sizes the saturating fill counter.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_dff_stage.sv
// One WIDTH-wide register with synchronous active-high reset to RESET_VAL.
module sync_dff_stage #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_q <= RESET_VAL;
        else         r_q <= i_d;
    end

    assign o_q = r_q;

endmodule

// File: rtl/sync_dff.sv
// Parameterized synchronous DFF pipeline with fill-tracking valid flag.
// Edge-detect outputs o_rise/o_fall exist only when SYNC_DFF_EDGE_DETECT_EN is defined.
module sync_dff
    import sync_dff_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter int               DEPTH     = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid
`ifdef SYNC_DFF_EDGE_DETECT_EN
    ,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall
`endif
);

    localparam int unsigned CW = clog2(DEPTH + 1);

    // w_chain[k] feeds stage k; w_chain[DEPTH] is the last stage output.
    logic [WIDTH-1:0] w_chain [DEPTH+1];
    logic [CW-1:0]    r_count;

    assign w_chain[0] = i_d;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        sync_dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_d     (w_chain[g]),
            .o_q     (w_chain[g+1])
        );
    end

    assign o_q = w_chain[DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset)                    r_count <= '0;
        else if (r_count != CW'(DEPTH)) r_count <= r_count + 1'b1;
    end

    assign o_valid = (r_count == CW'(DEPTH));

`ifdef SYNC_DFF_EDGE_DETECT_EN
    logic [WIDTH-1:0] r_prev;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_prev <= RESET_VAL;
        else         r_prev <= w_chain[DEPTH];
    end

    assign o_rise = w_chain[DEPTH] & ~r_prev;
    assign o_fall = ~w_chain[DEPTH] & r_prev;
`endif

endmodule

// File: tb/tb_sync_dff.sv
// Self-checking bench for sync_dff: default 1x1 instance and an 8-bit, 3-deep instance.
module tb_sync_dff;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d0  = 1'b0;
    logic [7:0] d1  = 8'h00;
    logic       q0, v0, q1v;
    logic [7:0] q1;

    int tests = 0;
    int fails = 0;

    // Reference model: bounded history of accepted samples per instance.
    logic       m0[$];
    logic [7:0] m1[$];
    logic       eq0 = 1'b0, prev0 = 1'b0;
    logic [7:0] eq1 = 8'hA5, prev1 = 8'hA5;

    always #5 clk = ~clk;

`ifdef SYNC_DFF_EDGE_DETECT_EN
    logic       rise0, fall0;
    logic [7:0] rise1, fall1;
`endif

    sync_dff u_dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_d     (d0),
        .o_q     (q0),
        .o_valid (v0)
`ifdef SYNC_DFF_EDGE_DETECT_EN
        ,
        .o_rise  (rise0),
        .o_fall  (fall0)
`endif
    );

    sync_dff #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'hA5)
    ) u_dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .i_d     (d1),
        .o_q     (q1),
        .o_valid (q1v)
`ifdef SYNC_DFF_EDGE_DETECT_EN
        ,
        .o_rise  (rise1),
        .o_fall  (fall1)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("q0", {7'b0, q0}, {7'b0, eq0});
        chk("valid0", {7'b0, v0}, {7'b0, (m0.size() == 1)});
        chk("q1", q1, eq1);
        chk("valid1", {7'b0, q1v}, {7'b0, (m1.size() == 3)});
`ifdef SYNC_DFF_EDGE_DETECT_EN
        chk("rise0", {7'b0, rise0}, {7'b0, eq0 & ~prev0});
        chk("fall0", {7'b0, fall0}, {7'b0, ~eq0 & prev0});
        chk("rise1", rise1, eq1 & ~prev1);
        chk("fall1", fall1, ~eq1 & prev1);
`endif
    endtask

    // Drive one cycle, advance the model at the edge, check 1 time unit later.
    task automatic step(input logic r, input logic a, input logic [7:0] b);
        rst = r;
        d0  = a;
        d1  = b;
        @(posedge clk);
        prev0 = eq0;
        prev1 = eq1;
        if (r) begin
            m0.delete();
            m1.delete();
            prev0 = 1'b0;
            prev1 = 8'hA5;
        end else begin
            m0.push_back(a);
            if (m0.size() > 1) void'(m0.pop_front());
            m1.push_back(b);
            if (m1.size() > 3) void'(m1.pop_front());
        end
        eq0 = (m0.size() == 1) ? m0[0] : 1'b0;
        eq1 = (m1.size() == 3) ? m1[0] : 8'hA5;
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held two cycles with data high: data must be ignored.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);

        // Directed sequences after reset.
        step(1'b0, 1'b1, 8'h01);
        step(1'b0, 1'b0, 8'h02);
        step(1'b0, 1'b1, 8'h03);
        step(1'b0, 1'b1, 8'h04);
        step(1'b0, 1'b0, 8'h05);
        step(1'b0, 1'b1, 8'h06);

        for (int i = 0; i < 40; i++)
            step(1'b0, 1'($urandom), 8'($urandom));

        // Mid-stream reset for one cycle, then refill.
        step(1'b1, 1'b1, 8'h3C);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'($urandom), 8'($urandom));

        // Reset pulses that never overlap a rising edge must have no effect.
        for (int i = 0; i < 4; i++) begin
            rst = 1'b1;
            #2;
            rst = 1'b0;
            #1;
            check_all();
            step(1'b0, 1'($urandom), 8'($urandom));
        end

        for (int i = 0; i < 60; i++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 8'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
